// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 INCR-burst SRAM slave, independent AR/R and AW/W/B FSMs, one outstanding txn each, SLVERR beyond DEPTH; ports i_clk, i_rst (async high), AXI AW/W/B/AR/R channels
module axi_sram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [3:0]              awid,
  input  logic [7:0]              awlen,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  output logic [3:0]              bid,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [3:0]              arid,
  input  logic [7:0]              arlen,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic [3:0]              rid
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int SB = $clog2(NB);
  localparam int MW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LIM = ADDR_WIDTH'(DEPTH);
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  r_state_t r_state;
  w_state_t w_state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_idx, r_nidx, w_idx;
  logic [7:0] r_cnt, r_ncnt, w_cnt;
  logic r_step, r_ok, w_beat, w_ok, w_err;
  assign arready = r_state == R_IDLE;
  assign rvalid  = r_state == R_DATA;
  assign awready = w_state == W_IDLE;
  assign wready  = w_state == W_DATA;
  assign bvalid  = w_state == W_RESP;
  always_comb begin
    r_step = (arvalid && arready) || (rvalid && rready && r_cnt != 8'd0);
    r_nidx = arready ? araddr >> SB : r_idx + ADDR_WIDTH'(1);
    r_ncnt = arready ? arlen : r_cnt - 8'd1;
    r_ok   = r_nidx < LIM;
    w_beat = wvalid && wready;
    w_ok   = w_idx < LIM;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state <= R_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rresp   <= 2'b00;
      rid     <= '0;
    end else if (r_step) begin
      r_state <= R_DATA;
      r_idx   <= r_nidx;
      r_cnt   <= r_ncnt;
      rlast   <= r_ncnt == 8'd0;
      rdata   <= r_ok ? mem[r_nidx[MW-1:0]] : '0;
      rresp   <= r_ok ? 2'b00 : 2'b10;
      rid     <= arready ? arid : rid;
    end else if (rvalid && rready) begin
      r_state <= R_IDLE;
      rlast   <= 1'b0;
    end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      w_state <= W_IDLE;
      w_idx   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      bresp   <= 2'b00;
      bid     <= '0;
    end else if (awvalid && awready) begin
      w_state <= W_DATA;
      w_idx   <= awaddr >> SB;
      w_cnt   <= awlen;
      w_err   <= 1'b0;
      bid     <= awid;
    end else if (w_beat) begin
      w_idx   <= w_idx + ADDR_WIDTH'(1);
      w_cnt   <= w_cnt - 8'd1;
      w_err   <= w_err || !w_ok;
      w_state <= w_cnt == 8'd0 ? W_RESP : W_DATA;
      bresp   <= w_cnt == 8'd0 ? ((w_err || !w_ok) ? 2'b10 : 2'b00) : bresp;
    end else if (bvalid && bready) begin
      w_state <= W_IDLE;
    end
  always_ff @(posedge i_clk)
    for (int b = 0; b < NB; b++)
      if (w_beat && w_ok && wstrb[b]) mem[w_idx[MW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
endmodule
